// File: rtl/multi_channel_timer_pkg.sv
// Shared register map and field positions for the multi-channel timer.
// Channel c occupies words 4c..4c+3; global words follow the last channel.
package multi_channel_timer_pkg;

    localparam logic [1:0] OFF_STATUS  = 2'd0;
    localparam logic [1:0] OFF_CONTROL = 2'd1;
    localparam logic [1:0] OFF_PERIOD  = 2'd2;
    localparam logic [1:0] OFF_SNAP    = 2'd3;

    localparam int unsigned GW_PENDING  = 0;
    localparam int unsigned GW_PRESCALE = 1;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam int STAT_TIMEOUT = 0;
    localparam int STAT_RUNNING = 1;

    function automatic int unsigned global_word(int unsigned num_ch, int unsigned gw);
        return num_ch * 4 + gw;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counter channel: period, control, force reload, running,
// timeout edge detect and snapshot, driven by pre-decoded strobes.
module timer_channel
    import multi_channel_timer_pkg::*;
#(
    parameter int          COUNTER_W      = 32,
    parameter logic [31:0] PERIOD_DEFAULT = 32'd49_999_999
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic        wr_status_i,
    input  logic        wr_control_i,
    input  logic        wr_period_i,
    input  logic        wr_snap_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] rdata_o,
    output logic        timeout_o,
    output logic        irq_o
);

    localparam logic [COUNTER_W-1:0] PDEF = PERIOD_DEFAULT[COUNTER_W-1:0];

    logic [COUNTER_W-1:0] counter_q, counter_d;
    logic [COUNTER_W-1:0] period_q, period_d;
    logic [COUNTER_W-1:0] snap_q, snap_d;
    logic [3:0]           ctrl_q, ctrl_d;
    logic                 running_q, running_d;
    logic                 timeout_q, timeout_d;
    logic                 reload_q, reload_d;
    logic                 zero_q, zero_d;
    logic                 zero, start, stop;
    logic                 unused_wdata;

    assign unused_wdata = ^wdata_i;

    always_comb begin
        zero      = (counter_q == '0);
        start     = wr_control_i & wdata_i[CTRL_START];
        stop      = wr_control_i & wdata_i[CTRL_STOP];
        period_d  = wr_period_i ? wdata_i[COUNTER_W-1:0] : period_q;
        ctrl_d    = wr_control_i ? wdata_i[3:0] : ctrl_q;
        snap_d    = wr_snap_i ? counter_q : snap_q;
        reload_d  = wr_period_i;
        counter_d = counter_q;
        if (reload_q || (tick_i && running_q)) begin
            counter_d = (reload_q || zero) ? period_q : counter_q - COUNTER_W'(1);
        end
        running_d = running_q;
        if (reload_q || (tick_i && zero && !ctrl_q[CTRL_CONT])) running_d = 1'b0;
        if (stop) running_d = 1'b0;
        if (start) running_d = 1'b1;
        // START re-arms the edge detect so a zero period still fires once
        zero_d    = zero & ~start;
        timeout_d = timeout_q;
        if (zero && !zero_q) timeout_d = 1'b1;
        if (wr_status_i) timeout_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            counter_q <= PDEF;
            period_q  <= PDEF;
            snap_q    <= '0;
            ctrl_q    <= '0;
            running_q <= 1'b0;
            timeout_q <= 1'b0;
            reload_q  <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            period_q  <= period_d;
            snap_q    <= snap_d;
            ctrl_q    <= ctrl_d;
            running_q <= running_d;
            timeout_q <= timeout_d;
            reload_q  <= reload_d;
            zero_q    <= zero_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (offset_i)
            OFF_STATUS: begin
                rdata_o[STAT_RUNNING] = running_q;
                rdata_o[STAT_TIMEOUT] = timeout_q;
            end
            OFF_CONTROL: rdata_o = 32'(ctrl_q);
            OFF_PERIOD:  rdata_o = 32'(period_q);
            OFF_SNAP:    rdata_o = 32'(snap_q);
            default:     rdata_o = '0;
        endcase
    end

    assign timeout_o = timeout_q;
    assign irq_o     = timeout_q & ctrl_q[CTRL_ITO];

endmodule

// File: rtl/multi_channel_timer.sv
// NUM_CH down-counter timers behind one Avalon-MM slave.
// Define MULTI_CHANNEL_TIMER_PRESCALE_EN for the shared 16-bit prescaler.
module multi_channel_timer
    import multi_channel_timer_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          COUNTER_W      = 32,
    parameter logic [31:0] PERIOD_DEFAULT = 32'd49_999_999,
    parameter int          ADDR_W         = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic [ADDR_W-1:0] address,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam logic [ADDR_W-1:0] PENDING_A = ADDR_W'(global_word(NUM_CH, GW_PENDING));

    logic              wr;
    logic              tick;
    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] timeout_vec;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [31:0]       readdata_q, readdata_d;

    assign wr = chipselect & ~write_n;

`ifdef MULTI_CHANNEL_TIMER_PRESCALE_EN
    localparam logic [ADDR_W-1:0] PRESCALE_A = ADDR_W'(global_word(NUM_CH, GW_PRESCALE));

    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pcnt_q, pcnt_d;

    assign tick = (pcnt_q == prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        pcnt_d     = tick ? '0 : pcnt_q + 16'd1;
        if (wr && address == PRESCALE_A) begin
            prescale_d = writedata[15:0];
            pcnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else begin
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_sel[c] = (address[ADDR_W-1:2] == (ADDR_W-2)'(c));

        timer_channel #(
            .COUNTER_W      (COUNTER_W),
            .PERIOD_DEFAULT (PERIOD_DEFAULT)
        ) u_ch (
            .clk_i        (clk),
            .reset_i      (reset),
            .tick_i       (tick),
            .wr_status_i  (wr & ch_sel[c] & (address[1:0] == OFF_STATUS)),
            .wr_control_i (wr & ch_sel[c] & (address[1:0] == OFF_CONTROL)),
            .wr_period_i  (wr & ch_sel[c] & (address[1:0] == OFF_PERIOD)),
            .wr_snap_i    (wr & ch_sel[c] & (address[1:0] == OFF_SNAP)),
            .wdata_i      (writedata),
            .offset_i     (address[1:0]),
            .rdata_o      (ch_rdata[c]),
            .timeout_o    (timeout_vec[c]),
            .irq_o        (irq_vec[c])
        );
    end

    always_comb begin
        readdata_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel[c]) readdata_d = ch_rdata[c];
        end
        if (address == PENDING_A) readdata_d = 32'(timeout_vec);
`ifdef MULTI_CHANNEL_TIMER_PRESCALE_EN
        if (address == PRESCALE_A) readdata_d = 32'(prescale_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) readdata_q <= '0;
        else       readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;
    assign irq      = |irq_vec;

endmodule
